// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with single-outstanding memory request
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

  state_t      state;
  logic [31:0] pc;
  // Set when the single outstanding response belongs to a redirected-away fetch
  logic        drop;

  logic [31:0] flush_aligned;
  logic [31:0] target_aligned;
  logic        flush_mis;
  logic        target_mis;
  logic [31:0] pc_seq;

  // Redirect addresses are word-aligned by dropping the low bits
  assign flush_aligned  = {flush_pc[31:2], 2'b00};
  assign target_aligned = {pc_target[31:2], 2'b00};
  assign flush_mis      = |flush_pc[1:0];
  assign target_mis     = |pc_target[1:0];
  assign pc_seq         = pc + 32'd4;

  // The request address is always the current PC; decode fields come straight off the held word
  assign imem_addr = pc;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[30];

  // Fetch FSM: all state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      instr       <= NOP;
      instr_pc    <= RESET_PC;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (flush) begin
            pc         <= flush_aligned;
            misaligned <= flush_mis;
          end
        end

        REQ: begin
          if (flush) begin
            pc         <= flush_aligned;
            misaligned <= flush_mis;
            // Memory takes the old address this cycle, so its answer must be thrown away
            if (imem_ready) begin
              drop     <= 1'b1;
              state    <= WAIT;
              imem_req <= 1'b0;
            end
          end else if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end

        WAIT: begin
          if (flush) begin
            pc         <= flush_aligned;
            misaligned <= flush_mis;
            if (imem_rvalid) begin
              // Response for the old address arrives now: discard it, nothing left outstanding
              drop     <= 1'b0;
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop) begin
              drop     <= 1'b0;
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= VALID;
            end
          end
        end

        VALID: begin
          if (flush) begin
            instr_valid <= 1'b0;
            pc          <= flush_aligned;
            misaligned  <= flush_mis;
            state       <= REQ;
            imem_req    <= 1'b1;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= REQ;
            imem_req    <= 1'b1;
            if (pc_src) begin
              pc         <= target_aligned;
              misaligned <= target_mis;
            end else begin
              pc <= pc_seq;
            end
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] instr,     instr2;
  logic [31:0] instr_pc,  instr_pc2;
  logic        instr_valid, instr_valid2;
  logic [6:0]  op,        op2;
  logic [2:0]  funct3,    funct3_2;
  logic        funct7,    funct7_2;
  logic        misaligned, misaligned2;

  int n_pass  = 0;
  int n_total = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target),
    .flush(flush), .flush_pc(flush_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .op(op), .funct3(funct3), .funct7(funct7), .misaligned(misaligned)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target),
    .flush(flush), .flush_pc(flush_pc), .stall(stall),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .op(op2), .funct3(funct3_2), .funct7(funct7_2), .misaligned(misaligned2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: inputs settle before the rising edge, outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (imem_req) req_cnt++;
  endtask

  // From REQ: accept the request, return data next cycle, land in VALID
  task automatic fetch(input logic [31:0] data);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_src = 1'b0; pc_target = '0; flush = 1'b0; flush_pc = '0;
    stall = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    step();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h13);
    check("rst_addr", imem_addr, 0);
    check("rst_mis", misaligned, 0);
    check("rst_ipc_wrap", instr_pc2, 32'hFFFF_FFFC);

    // First fetch: request in cycle 1, instruction valid in cycle 3
    rst = 1'b0;
    req_cnt = 0;
    step();
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 0);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("c2_req", imem_req, 0);
    check("c2_valid", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    check("c3_valid", instr_valid, 1);
    check("c3_op", op, 7'h13);
    check("c3_funct3", funct3, 0);
    check("c3_ipc", instr_pc, 0);

    // Sequential fetches
    step();
    check("seq_addr4", imem_addr, 4);
    check("seq_valid_drop", instr_valid, 0);
    fetch(32'h4000_5033);
    check("seq_ipc4", instr_pc, 4);
    check("dec_op", op, 7'h33);
    check("dec_funct3", funct3, 5);
    check("dec_funct7", funct7, 1);
    step();
    check("seq_addr8", imem_addr, 8);
    fetch(32'h0000_0513);
    check("seq_ipc8", instr_pc, 8);
    check("req_once_each", req_cnt, 3);

    // Stall holds the instruction; branch target is ignored while stalled
    stall = 1'b1; pc_src = 1'b1; pc_target = 32'h40;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, 32'h0000_0513);
      check("stall_ipc", instr_pc, 8);
      check("stall_addr", imem_addr, 8);
    end
    stall = 1'b0; pc_target = 32'h100;
    step();
    pc_src = 1'b0;
    check("br_addr", imem_addr, 32'h100);
    check("br_mis", misaligned, 0);

    // Misaligned branch target
    fetch(32'h0010_0113);
    check("br_ipc", instr_pc, 32'h100);
    pc_src = 1'b1; pc_target = 32'h0000_0102;
    step();
    pc_src = 1'b0;
    check("mis_addr", imem_addr, 32'h100);
    check("mis_pulse", misaligned, 1);
    step();
    check("mis_clear", misaligned, 0);

    // Flush in WAIT, late response dropped
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h200;
    step();
    flush = 1'b0;
    check("fw_addr", imem_addr, 32'h200);
    check("fw_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("fw_valid", instr_valid, 0);
    check("fw_instr_kept", instr, 32'h0010_0113);
    check("fw_next_addr", imem_addr, 32'h200);
    check("fw_next_req", imem_req, 1);

    // Flush in REQ while memory accepts the old address
    imem_ready = 1'b1; flush = 1'b1; flush_pc = 32'h300;
    step();
    imem_ready = 1'b0; flush = 1'b0;
    check("fr_addr", imem_addr, 32'h300);
    check("fr_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("fr_valid", instr_valid, 0);
    check("fr_req_again", imem_req, 1);

    // Flush in VALID beats stall, misaligned redirect
    fetch(32'h1111_1111);
    check("fv_pre_ipc", instr_pc, 32'h300);
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h402;
    step();
    stall = 1'b0; flush = 1'b0;
    check("fv_valid", instr_valid, 0);
    check("fv_addr", imem_addr, 32'h400);
    check("fv_mis", misaligned, 1);

    // Flush in REQ without acceptance: address follows next cycle
    flush = 1'b1; flush_pc = 32'h500;
    step();
    flush = 1'b0;
    check("frn_addr", imem_addr, 32'h500);
    check("frn_req", imem_req, 1);

    // Stray response in REQ is ignored
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("stray_valid", instr_valid, 0);
    check("stray_req", imem_req, 1);

    // Reset mid-fetch, late response in IDLE ignored
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_instr", instr, 32'h13);
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("late_valid", instr_valid, 0);
    check("wrap_start", imem_addr2, 32'hFFFF_FFFC);

    // PC wraps modulo 2^32
    fetch(32'h0000_0013);
    check("wrap_ipc", instr_pc2, 32'hFFFF_FFFC);
    check("wrap_valid", instr_valid2, 1);
    step();
    check("wrap_addr", imem_addr2, 32'h0);
    check("nowrap_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
